// File: rtl/dmem_responder_if.sv
// Data-port bundle between the cpu and dmem_responder.
// The cpu drives the address/write side; the responder drives the read data and error flags.
interface dmem_responder_if;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;
   logic [31:0] drdata;
   logic        derr;
   logic        derr_sticky;

   modport master (
      output daddr,
      output dwdata,
      output dwe,
      input  drdata,
      input  derr,
      input  derr_sticky
   );

   modport slave (
      input  daddr,
      input  dwdata,
      input  dwe,
      output drdata,
      output derr,
      output derr_sticky
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane-writable word RAM with write-first forwarding,
// a READ_LAT-deep read pipe and out-of-range error flagging.
module dmem_responder #(
   parameter int unsigned AW       = 10,
   parameter int unsigned READ_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   dmem_responder_if.slave bus
);

   if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
      $error("dmem_responder: READ_LAT must be in 1..4");
   end
   if (AW < 1 || AW > 29) begin : g_bad_aw
      $error("dmem_responder: AW must be in 1..29");
   end

   logic [31:0]   mem [2**AW];
   logic [AW-1:0] idx;
   logic          in_range;
   logic [31:0]   rd_word;
   logic [31:0]   s0_data;
   logic          s0_err;
   logic [31:0]   pipe_data [READ_LAT];
   logic          pipe_err  [READ_LAT];
   logic          sticky;
   logic          unused_byte_offset;

   assign idx                = bus.daddr[AW+1:2];
   assign in_range           = (bus.daddr[31:AW+2] == '0);
   assign rd_word            = mem[idx];
   assign unused_byte_offset = ^bus.daddr[1:0];

   // Stage-0 value: stored word with this cycle's enabled lanes overlaid (write-first).
   always_comb begin
      s0_data = '0;
      s0_err  = 1'b1;
      if (in_range) begin
         s0_err  = 1'b0;
         s0_data = rd_word;
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.dwe[i]) begin
               s0_data[8*i +: 8] = bus.dwdata[8*i +: 8];
            end
         end
      end
   end

   // RAM shares this block so writes are inhibited during reset; its contents are never cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned s = 0; s < READ_LAT; s++) begin
            pipe_data[s] <= '0;
            pipe_err[s]  <= 1'b0;
         end
         sticky <= 1'b0;
      end else begin
         if (in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (bus.dwe[i]) begin
                  mem[idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
               end
            end
         end
         pipe_data[0] <= s0_data;
         pipe_err[0]  <= s0_err;
         for (int unsigned s = 1; s < READ_LAT; s++) begin
            pipe_data[s] <= pipe_data[s-1];
            pipe_err[s]  <= pipe_err[s-1];
         end
         sticky <= sticky | s0_err;
      end
   end

   assign bus.drdata      = pipe_data[READ_LAT-1];
   assign bus.derr        = pipe_err[READ_LAT-1];
   assign bus.derr_sticky = sticky;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (READ_LAT 1, 3, 4) share stimulus and are
// compared against a word-map / result-history reference model.
module tb_dmem_responder;
   localparam int unsigned AW   = 10;
   localparam int          NDUT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;

   dmem_responder_if if_l1 ();
   dmem_responder_if if_l3 ();
   dmem_responder_if if_l4 ();

   assign if_l1.daddr = daddr;  assign if_l1.dwdata = dwdata;  assign if_l1.dwe = dwe;
   assign if_l3.daddr = daddr;  assign if_l3.dwdata = dwdata;  assign if_l3.dwe = dwe;
   assign if_l4.daddr = daddr;  assign if_l4.dwdata = dwdata;  assign if_l4.dwe = dwe;

   dmem_responder #(.AW(AW), .READ_LAT(1)) u_lat1 (.clk(clk), .reset(reset), .bus(if_l1.slave));
   dmem_responder #(.AW(AW), .READ_LAT(3)) u_lat3 (.clk(clk), .reset(reset), .bus(if_l3.slave));
   dmem_responder #(.AW(AW), .READ_LAT(4)) u_lat4 (.clk(clk), .reset(reset), .bus(if_l4.slave));

   logic [31:0] act_d [NDUT];
   logic        act_e [NDUT];
   logic        act_s [NDUT];
   assign act_d[0] = if_l1.drdata;  assign act_e[0] = if_l1.derr;  assign act_s[0] = if_l1.derr_sticky;
   assign act_d[1] = if_l3.drdata;  assign act_e[1] = if_l3.derr;  assign act_s[1] = if_l3.derr_sticky;
   assign act_d[2] = if_l4.drdata;  assign act_e[2] = if_l4.derr;  assign act_s[2] = if_l4.derr_sticky;

   always #5 clk = ~clk;

   // Reference model: word map plus the list of per-cycle results since the last reset.
   logic [31:0] mm [int unsigned];
   logic [31:0] hist_d [$];
   logic        hist_e [$];
   logic        m_sticky;
   int          n_checks = 0;
   int          n_pass   = 0;

   function automatic int lat_of(int k);
      case (k)
         0:       return 1;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] exp_d(int l);
      if (hist_d.size() >= l) return hist_d[hist_d.size() - l];
      return 32'h0;
   endfunction

   function automatic logic exp_e(int l);
      if (hist_e.size() >= l) return hist_e[hist_e.size() - l];
      return 1'b0;
   endfunction

   task automatic model_clear();
      hist_d.delete();
      hist_e.delete();
      m_sticky = 1'b0;
   endtask

   task automatic step();
      logic [31:0] w;
      int unsigned widx;
      @(posedge clk);
      if (reset !== 1'b1) begin
         model_clear();
      end else if ((daddr >> (AW + 2)) != 0) begin
         hist_d.push_back(32'h0);
         hist_e.push_back(1'b1);
         m_sticky = 1'b1;
      end else begin
         widx = (daddr >> 2) % (32'd1 << AW);
         w = mm.exists(widx) ? mm[widx] : 32'h0;
         for (int i = 0; i < 4; i++) begin
            if (dwe[i]) w = (w & ~(32'hFF << (8 * i))) | (dwdata & (32'hFF << (8 * i)));
         end
         if (dwe != 4'h0) mm[widx] = w;
         hist_d.push_back(w);
         hist_e.push_back(1'b0);
      end
      if (hist_d.size() > 8) begin
         void'(hist_d.pop_front());
         void'(hist_e.pop_front());
      end
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      daddr  = a;
      dwdata = d;
      dwe    = we;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(32'h0, 32'h0, 4'h0);
      model_clear();
      step();
      step();
      for (int k = 0; k < NDUT; k++) begin
         n_checks++;
         if (act_d[k] !== 32'h0 || act_e[k] !== 1'b0 || act_s[k] !== 1'b0)
            $display("FAIL reset lat=%0d: got %h/%b/%b want 00000000/0/0", lat_of(k), act_d[k], act_e[k], act_s[k]);
         else n_pass++;
      end
      reset = 1'b1;
   endtask

   task automatic test_byte_merge();
      for (int j = 0; j < 6; j++) begin
         case (j)
            0:       drive(32'h10, 32'hDEADBEEF, 4'hF);
            1:       drive(32'h10, 32'h0000AA00, 4'b0010);
            default: drive(32'h10, 32'h0, 4'h0);
         endcase
         step();
         for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (act_d[k] !== exp_d(lat_of(k)) || act_e[k] !== exp_e(lat_of(k)) || act_s[k] !== m_sticky)
               $display("FAIL merge lat=%0d: got %h/%b/%b want %h/%b/%b", lat_of(k), act_d[k], act_e[k], act_s[k], exp_d(lat_of(k)), exp_e(lat_of(k)), m_sticky);
            else n_pass++;
         end
         if (j >= 1) begin
            n_checks++;
            if (act_d[0] !== 32'hDEADAAEF) $display("FAIL merge_const: drdata=%h want DEADAAEF", act_d[0]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 9; j++) begin
         if (j < 3)      drive(32'(4 * j), 32'(j + 1), 4'hF);
         else if (j < 6) drive(32'(4 * (j - 3)), 32'h0, 4'h0);
         else            drive(32'h10, 32'h0, 4'h0);
         step();
         for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (act_d[k] !== exp_d(lat_of(k)) || act_e[k] !== exp_e(lat_of(k)) || act_s[k] !== m_sticky)
               $display("FAIL b2b lat=%0d: got %h/%b/%b want %h/%b/%b", lat_of(k), act_d[k], act_e[k], act_s[k], exp_d(lat_of(k)), exp_e(lat_of(k)), m_sticky);
            else n_pass++;
         end
         if (j >= 3 && j <= 5) begin
            n_checks++;
            if (act_d[0] !== 32'(j - 2)) $display("FAIL b2b_lat1: drdata=%h want %h", act_d[0], 32'(j - 2));
            else n_pass++;
         end
         if (j >= 5 && j <= 7) begin
            n_checks++;
            if (act_d[1] !== 32'(j - 4)) $display("FAIL b2b_lat3: drdata=%h want %h", act_d[1], 32'(j - 4));
            else n_pass++;
         end
      end
   endtask

   task automatic test_forward();
      for (int j = 0; j < 6; j++) begin
         case (j)
            0:       drive(32'h20, 32'h11223344, 4'hF);
            1:       drive(32'h20, 32'hFF000000, 4'b1000);
            default: drive(32'h20, 32'h0, 4'h0);
         endcase
         step();
         for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (act_d[k] !== exp_d(lat_of(k)) || act_e[k] !== exp_e(lat_of(k)) || act_s[k] !== m_sticky)
               $display("FAIL fwd lat=%0d: got %h/%b/%b want %h/%b/%b", lat_of(k), act_d[k], act_e[k], act_s[k], exp_d(lat_of(k)), exp_e(lat_of(k)), m_sticky);
            else n_pass++;
         end
         if (j >= 1) begin
            n_checks++;
            if (act_d[0] !== 32'hFF223344) $display("FAIL fwd_const: drdata=%h want FF223344", act_d[0]);
            else n_pass++;
         end
      end
      n_checks++;
      if (act_d[2] !== 32'hFF223344) $display("FAIL fwd_lat4: drdata=%h want FF223344", act_d[2]);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      for (int j = 0; j < 6; j++) begin
         if (j == 0) drive(32'h1 << (AW + 2), 32'h12345678, 4'hF);
         else        drive(32'h0, 32'h0, 4'h0);
         step();
         for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (act_d[k] !== exp_d(lat_of(k)) || act_e[k] !== exp_e(lat_of(k)) || act_s[k] !== m_sticky)
               $display("FAIL oor lat=%0d: got %h/%b/%b want %h/%b/%b", lat_of(k), act_d[k], act_e[k], act_s[k], exp_d(lat_of(k)), exp_e(lat_of(k)), m_sticky);
            else n_pass++;
         end
         n_checks++;
         if (j == 0 && (act_d[0] !== 32'h0 || act_e[0] !== 1'b1 || act_s[0] !== 1'b1))
            $display("FAIL oor_flag: got %h/%b/%b want 00000000/1/1", act_d[0], act_e[0], act_s[0]);
         else if (j > 0 && (act_d[0] !== 32'h1 || act_e[0] !== 1'b0 || act_s[0] !== 1'b1))
            $display("FAIL oor_noalias: got %h/%b/%b want 00000001/0/1", act_d[0], act_e[0], act_s[0]);
         else n_pass++;
      end
   endtask

   task automatic test_misaligned();
      for (int j = 0; j < 5; j++) begin
         drive(32'h13, 32'h0, 4'h0);
         step();
         for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (act_d[k] !== exp_d(lat_of(k)) || act_e[k] !== exp_e(lat_of(k)) || act_s[k] !== m_sticky)
               $display("FAIL misalign lat=%0d: got %h/%b/%b want %h/%b/%b", lat_of(k), act_d[k], act_e[k], act_s[k], exp_d(lat_of(k)), exp_e(lat_of(k)), m_sticky);
            else n_pass++;
         end
      end
      n_checks++;
      if (act_d[0] !== 32'hDEADAAEF || act_e[0] !== 1'b0)
         $display("FAIL misalign_const: got %h/%b want DEADAAEF/0", act_d[0], act_e[0]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0] we;
      for (int j = 0; j < 64 + 300; j++) begin
         if (j < 64) begin
            drive(32'(4 * j), $urandom, 4'hF);
         end else begin
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
               drive((32'($urandom_range(1, 32'hFFFFF)) << 12) | 32'($urandom_range(0, 4095)), $urandom, we);
            else
               drive((32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)), $urandom, we);
         end
         step();
         for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (act_d[k] !== exp_d(lat_of(k)) || act_e[k] !== exp_e(lat_of(k)) || act_s[k] !== m_sticky)
               $display("FAIL random lat=%0d cyc=%0d: got %h/%b/%b want %h/%b/%b", lat_of(k), j, act_d[k], act_e[k], act_s[k], exp_d(lat_of(k)), exp_e(lat_of(k)), m_sticky);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_midflight();
      for (int j = 0; j < 6; j++) begin
         if (j < 3) drive(32'(4 * j), 32'(32'hA1 + j), 4'hF);
         else       drive(32'(4 * (j - 3)), 32'h0, 4'h0);
         step();
      end
      reset = 1'b0;
      #1;
      model_clear();
      for (int k = 0; k < NDUT; k++) begin
         n_checks++;
         if (act_d[k] !== 32'h0 || act_e[k] !== 1'b0 || act_s[k] !== 1'b0)
            $display("FAIL midreset lat=%0d: got %h/%b/%b want 00000000/0/0", lat_of(k), act_d[k], act_e[k], act_s[k]);
         else n_pass++;
      end
      step();
      step();
      reset = 1'b1;
      drive(32'h4, 32'h0, 4'h0);
      for (int j = 1; j <= 4; j++) begin
         step();
         for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (act_d[k] !== exp_d(lat_of(k)) || act_e[k] !== exp_e(lat_of(k)) || act_s[k] !== m_sticky)
               $display("FAIL postreset lat=%0d: got %h/%b/%b want %h/%b/%b", lat_of(k), act_d[k], act_e[k], act_s[k], exp_d(lat_of(k)), exp_e(lat_of(k)), m_sticky);
            else n_pass++;
         end
         n_checks++;
         if (j < 4 && act_d[2] !== 32'h0) $display("FAIL postreset_lat4_early: drdata=%h want 00000000", act_d[2]);
         else if (j == 4 && act_d[2] !== 32'hA2) $display("FAIL postreset_lat4: drdata=%h want 000000A2", act_d[2]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_byte_merge();
      test_back_to_back();
      test_forward();
      test_out_of_range();
      test_misaligned();
      test_random();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, passed=%0d of %0d", n_pass, n_checks);
      $fatal(1, "timeout");
   end

endmodule
